// File: rtl/dmem_arbiter.sv
// Two-port arbiter and IDLE/ACCESS/RESP sequencer for the single-port data memory.
// Optional feature macro: DMEM_ARB_RR_EN (round-robin arbitration instead of fixed CPU priority).
module dmem_arbiter #(
   parameter int AW       = 17,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [31:0]   cpu_wdata,
   input  logic [3:0]    cpu_be,
   input  logic          ext_req,
   input  logic          ext_we,
   input  logic [AW-1:0] ext_addr,
   input  logic [31:0]   ext_wdata,
   input  logic [3:0]    ext_be,
   output logic          cpu_gnt,
   output logic          ext_gnt,
   output logic          cpu_rvalid,
   output logic          ext_rvalid,
   output logic [31:0]   cpu_rdata,
   output logic [31:0]   ext_rdata,
   output logic          cpu_stall,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic [3:0]    mem_be,
   input  logic [31:0]   mem_rdata,
   output logic [1:0]    dbg_state
);

   // Handshake: a requester holds req and its command stable until gnt; gnt is a
   // same-cycle acceptance, and the matching rvalid is a single pulse two cycles later.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            owner_q, owner_d;        // 0 = CPU, 1 = external
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [3:0]      be_q, be_d;
   logic            resp_gnt_q, resp_gnt_d;  // CPU access was granted out of RESP
   logic            arb_open;
   logic            pick_ext;
   logic            any_gnt;

`ifdef DMEM_ARB_RR_EN
   // Holds the requester favoured on the next contention; the last winner yields.
   logic            prio_q, prio_d;
`else
   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
   logic [3:0]      wait_q, wait_d;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         resp_gnt_q <= 1'b0;
`ifdef DMEM_ARB_RR_EN
         prio_q     <= 1'b0;
`else
         wait_q     <= '0;
`endif
      end else begin
         owner_q    <= owner_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         resp_gnt_q <= resp_gnt_d;
`ifdef DMEM_ARB_RR_EN
         prio_q     <= prio_d;
`else
         wait_q     <= wait_d;
`endif
      end
   end

   // Arbitration; grants are only possible from IDLE or RESP and never during reset.
   always_comb begin
      arb_open = rst && ((state_q == S_IDLE) || (state_q == S_RESP));
`ifdef DMEM_ARB_RR_EN
      pick_ext = ext_req && (!cpu_req || prio_q);
`else
      pick_ext = ext_req && (!cpu_req || (wait_q == MAX_WAIT_C));
`endif
      cpu_gnt  = arb_open && cpu_req && !pick_ext;
      ext_gnt  = arb_open && pick_ext;
      any_gnt  = cpu_gnt || ext_gnt;
   end

`ifdef DMEM_ARB_RR_EN
   always_comb begin
      prio_d = prio_q;
      if (cpu_gnt) begin
         prio_d = 1'b1;
      end else if (ext_gnt) begin
         prio_d = 1'b0;
      end
   end
`else
   always_comb begin
      wait_d = wait_q;
      if (!ext_req || ext_gnt) begin
         wait_d = '0;
      end else if (cpu_gnt && (wait_q != MAX_WAIT_C)) begin
         wait_d = wait_q + 4'd1;
      end
   end
`endif

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      resp_gnt_d = resp_gnt_q;
      case (state_q)
         S_IDLE:   state_d = any_gnt ? S_ACCESS : S_IDLE;
         S_ACCESS: state_d = S_RESP;
         S_RESP:   state_d = any_gnt ? S_ACCESS : S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      if (any_gnt) begin
         owner_d    = ext_gnt;
         we_d       = ext_gnt ? ext_we    : cpu_we;
         addr_d     = ext_gnt ? ext_addr  : cpu_addr;
         wdata_d    = ext_gnt ? ext_wdata : cpu_wdata;
         be_d       = ext_gnt ? ext_be    : cpu_be;
         resp_gnt_d = cpu_gnt && (state_q == S_RESP);
      end
   end

   always_comb begin
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_be     = '0;
      cpu_rvalid = 1'b0;
      ext_rvalid = 1'b0;
      cpu_rdata  = '0;
      ext_rdata  = '0;
      if (state_q == S_ACCESS) begin
         mem_en    = 1'b1;
         mem_we    = we_q;
         mem_addr  = addr_q;
         mem_wdata = wdata_q;
         mem_be    = be_q;
      end
      if (state_q == S_RESP) begin
         if (owner_q) begin
            ext_rvalid = 1'b1;
            ext_rdata  = we_q ? 32'h0 : mem_rdata;
         end else begin
            cpu_rvalid = 1'b1;
            cpu_rdata  = we_q ? 32'h0 : mem_rdata;
         end
      end
      // A CPU access chained out of RESP keeps the stall up through its own RESP.
      cpu_stall = rst && (((state_q == S_ACCESS) && !owner_q) ||
                          ((state_q == S_RESP) && !owner_q && resp_gnt_q) ||
                          (cpu_req && !cpu_rvalid));
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter (default fixed-priority build): directed
// scenarios plus a randomized run scored against a cycle-timed reference model.
module tb_dmem_arbiter;
   localparam int AW       = 17;
   localparam int MAX_WAIT = 4;

   logic          clk;
   logic          rst;
   logic          cpu_req, ext_req, cpu_we, ext_we;
   logic [AW-1:0] cpu_addr, ext_addr;
   logic [31:0]   cpu_wdata, ext_wdata;
   logic [3:0]    cpu_be, ext_be;
   logic          cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, cpu_stall;
   logic [31:0]   cpu_rdata, ext_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata, mem_rdata;
   logic [3:0]    mem_be;
   logic [1:0]    dbg_state;

   int n_pass  = 0;
   int n_total = 0;

   // Environment RAM: 64 words indexed by addr[7:2], one-cycle read latency.
   bit   [31:0]   ram [0:63];
   logic          bd_we = 1'b0;
   logic [5:0]    bd_idx = '0;
   logic [31:0]   bd_data = '0;
   logic [31:0]   ref_mem [0:63];
   logic [64:0]   exp_q [$];  // {due_cycle[31:0], owner, data}

   dmem_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_be(ext_be),
      .cpu_gnt(cpu_gnt), .ext_gnt(ext_gnt), .cpu_rvalid(cpu_rvalid), .ext_rvalid(ext_rvalid),
      .cpu_rdata(cpu_rdata), .ext_rdata(ext_rdata), .cpu_stall(cpu_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_rdata(mem_rdata), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bd_we) begin
         ram[bd_idx] <= bd_data;
      end else if (mem_en) begin
         mem_rdata <= ram[mem_addr[7:2]];
         if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_be[b]) ram[mem_addr[7:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
      ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0; ext_be = '0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic backdoor_write(input logic [5:0] idx, input logic [31:0] data);
      @(negedge clk);
      bd_we = 1'b1; bd_idx = idx; bd_data = data;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      cpu_req = 1'b1;
      ext_req = 1'b1;
      idle_cycles(3);
      #1;
      n_total++;
      if ({cpu_gnt, ext_gnt, cpu_stall} !== 3'b000) $display("FAIL reset_gnt_stall: got %b want 000", {cpu_gnt, ext_gnt, cpu_stall});
      else n_pass++;
      idle_inputs();
      #1;
      n_total++;
      if ({cpu_rvalid, ext_rvalid, mem_en, mem_we, mem_addr, mem_wdata, mem_be, cpu_rdata, ext_rdata, dbg_state} !== '0)
         $display("FAIL reset_outputs: got en=%b we=%b addr=%h st=%0d want all zero", mem_en, mem_we, mem_addr, dbg_state);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      idle_cycles(2);
      #1;
      n_total++;
      if ({cpu_gnt, ext_gnt, cpu_stall, mem_en, dbg_state} !== 5'b0) $display("FAIL reset_release_idle: got %b want 00000", {cpu_gnt, ext_gnt, cpu_stall, mem_en, dbg_state});
      else n_pass++;
   endtask

   task automatic test_single_read();
      backdoor_write(6'd4, 32'hDEADBEEF);
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 17'h00010; cpu_be = 4'hF;
      #1;
      n_total++;
      if ({cpu_gnt, ext_gnt, cpu_stall, mem_en} !== 4'b1010) $display("FAIL read_c1: got gnt/egnt/stall/en=%b want 1010", {cpu_gnt, ext_gnt, cpu_stall, mem_en});
      else n_pass++;
      @(negedge clk);
      cpu_req = 0;
      #1;
      n_total++;
      if ({mem_en, mem_we, mem_addr, cpu_stall, cpu_rvalid, cpu_gnt} !== {1'b1, 1'b0, 17'h00010, 1'b1, 1'b0, 1'b0})
         $display("FAIL read_c2: got en=%b we=%b addr=%h stall=%b rv=%b gnt=%b want 1 0 00010 1 0 0", mem_en, mem_we, mem_addr, cpu_stall, cpu_rvalid, cpu_gnt);
      else n_pass++;
      @(negedge clk);
      #1;
      n_total++;
      if ({cpu_rvalid, cpu_rdata, cpu_stall, mem_en, ext_rvalid} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0})
         $display("FAIL read_c3: got rv=%b rdata=%h stall=%b en=%b want 1 deadbeef 0 0", cpu_rvalid, cpu_rdata, cpu_stall, mem_en);
      else n_pass++;
      idle_cycles(2);
   endtask

   task automatic test_ext_write_cpu_read();
      @(negedge clk);
      ext_req = 1; ext_we = 1; ext_addr = 17'h00020; ext_wdata = 32'h12345678; ext_be = 4'b0011;
      #1;
      n_total++;
      if ({ext_gnt, cpu_gnt} !== 2'b10) $display("FAIL wr_gnt: got ext/cpu=%b want 10", {ext_gnt, cpu_gnt});
      else n_pass++;
      @(negedge clk);
      ext_req = 0;
      #1;
      n_total++;
      if ({mem_en, mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 1'b1, 17'h00020, 32'h12345678, 4'b0011})
         $display("FAIL wr_access: got en=%b we=%b addr=%h wd=%h be=%b", mem_en, mem_we, mem_addr, mem_wdata, mem_be);
      else n_pass++;
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 17'h00020; cpu_be = 4'hF;
      #1;
      n_total++;
      if ({ext_rvalid, ext_rdata, cpu_gnt} !== {1'b1, 32'h0, 1'b1}) $display("FAIL wr_resp: got rv=%b rdata=%h cgnt=%b want 1 0 1", ext_rvalid, ext_rdata, cpu_gnt);
      else n_pass++;
      @(negedge clk);
      cpu_req = 0;
      #1;
      n_total++;
      if ({mem_en, cpu_stall} !== 2'b11) $display("FAIL rd_chain_access: got en/stall=%b want 11", {mem_en, cpu_stall});
      else n_pass++;
      @(negedge clk);
      #1;
      n_total++;
      if ({cpu_rvalid, cpu_rdata, cpu_stall} !== {1'b1, 32'h00005678, 1'b1})
         $display("FAIL rd_chain_resp: got rv=%b rdata=%h stall=%b want 1 00005678 1", cpu_rvalid, cpu_rdata, cpu_stall);
      else n_pass++;
      idle_cycles(2);
   endtask

   task automatic test_fixed_priority();
      string order = "CCCCECCCCE";
      logic  exp_c, exp_e;
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 17'h00004; cpu_be = 4'hF;
      ext_req = 1; ext_we = 0; ext_addr = 17'h00008; ext_be = 4'hF;
      for (int k = 0; k < 20; k++) begin
         #1;
         exp_c = (k % 2 == 0) && (order[k/2] == "C");
         exp_e = (k % 2 == 0) && (order[k/2] == "E");
         n_total++;
         if ({cpu_gnt, ext_gnt} !== {exp_c, exp_e}) $display("FAIL prio_order k=%0d: got cpu/ext=%b want %b", k, {cpu_gnt, ext_gnt}, {exp_c, exp_e});
         else n_pass++;
         @(negedge clk);
      end
      idle_inputs();
      idle_cycles(3);
   endtask

   task automatic test_drop_before_grant();
      @(negedge clk);
      ext_req = 1; ext_we = 0; ext_addr = 17'h00030; ext_be = 4'hF;
      #1;
      n_total++;
      if (ext_gnt !== 1'b1) $display("FAIL drop_ext_gnt: got %b want 1", ext_gnt);
      else n_pass++;
      @(negedge clk);
      ext_req = 0;
      cpu_req = 1; cpu_we = 1; cpu_addr = 17'h00034; cpu_wdata = 32'hA5A5A5A5; cpu_be = 4'hF;
      #1;
      n_total++;
      if ({cpu_stall, cpu_gnt} !== 2'b10) $display("FAIL drop_access_stall: got stall/gnt=%b want 10", {cpu_stall, cpu_gnt});
      else n_pass++;
      @(negedge clk);
      cpu_req = 0;
      #1;
      n_total++;
      if ({ext_rvalid, cpu_gnt, cpu_stall} !== 3'b100) $display("FAIL drop_resp: got rv/gnt/stall=%b want 100", {ext_rvalid, cpu_gnt, cpu_stall});
      else n_pass++;
      @(negedge clk);
      #1;
      n_total++;
      if ({mem_en, cpu_gnt, ext_gnt, cpu_rvalid} !== 4'b0) $display("FAIL drop_no_access: got en/gnt/egnt/rv=%b want 0000", {mem_en, cpu_gnt, ext_gnt, cpu_rvalid});
      else n_pass++;
      n_total++;
      if (ram[13] !== 32'h0) $display("FAIL drop_ram: got %h want 0", ram[13]);
      else n_pass++;
      idle_cycles(1);
   endtask

   task automatic test_reset_mid_write();
      @(negedge clk);
      ext_req = 1; ext_we = 1; ext_addr = 17'h00040; ext_wdata = 32'hCAFEF00D; ext_be = 4'hF;
      #1;
      n_total++;
      if (ext_gnt !== 1'b1) $display("FAIL rstw_gnt: got %b want 1", ext_gnt);
      else n_pass++;
      @(negedge clk);
      ext_req = 0;
      #1;
      n_total++;
      if ({mem_en, mem_we} !== 2'b11) $display("FAIL rstw_access: got en/we=%b want 11", {mem_en, mem_we});
      else n_pass++;
      rst = 1'b0;
      #1;
      n_total++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) $display("FAIL rstw_drop: got en=%b we=%b addr=%h want 0", mem_en, mem_we, mem_addr);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         n_total++;
         if ({cpu_rvalid, ext_rvalid} !== 2'b00) $display("FAIL rstw_no_rvalid: got %b want 00", {cpu_rvalid, ext_rvalid});
         else n_pass++;
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_total++;
      if ({cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, cpu_rdata, ext_rdata, cpu_stall, mem_en, mem_we, mem_addr, mem_wdata, mem_be, dbg_state} !== '0)
         $display("FAIL rstw_release: got st=%0d en=%b rv=%b%b want all zero", dbg_state, mem_en, cpu_rvalid, ext_rvalid);
      else n_pass++;
      n_total++;
      if (ram[16] !== 32'h0) $display("FAIL rstw_ram: got %h want 0", ram[16]);
      else n_pass++;
      idle_cycles(2);
   endtask

   // Reference model: a grant may occur in any cycle except the one right after a
   // grant; the access appears on the memory one cycle later and completes two later.
   task automatic test_random();
      int            last_g = -10;
      int            cpu_g = -10;
      bit            cpu_g_b2b = 0;
      int            cnt = 0;
      bit            c_pend = 0, e_pend = 0;
      logic          exp_c, exp_e, can;
      logic          c_we, c_rv, e_rv, exp_stall, b2b;
      logic [AW-1:0] c_addr;
      logic [31:0]   c_wdata, c_rd, e_rd, rd;
      logic [3:0]    c_be;
      logic [5:0]    idx;
      logic [64:0]   ent;
      for (int i = 0; i < 64; i++) ref_mem[i] = ram[i];
      c_we = 0; c_addr = '0; c_wdata = '0; c_be = '0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge clk);
         if (c_pend && $urandom_range(0, 99) < 5) begin c_pend = 0; cpu_req = 0; end
         if (e_pend && $urandom_range(0, 99) < 5) begin e_pend = 0; ext_req = 0; end
         if (!c_pend) begin
            cpu_req = 0;
            if ($urandom_range(0, 99) < 55) begin
               c_pend = 1; cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
               cpu_addr = {9'($urandom), 2'b10, 4'($urandom), 2'($urandom)};
               cpu_wdata = $urandom; cpu_be = 4'($urandom);
            end
         end
         if (!e_pend) begin
            ext_req = 0;
            if ($urandom_range(0, 99) < 45) begin
               e_pend = 1; ext_req = 1; ext_we = 1'($urandom_range(0, 1));
               ext_addr = {9'($urandom), 2'b10, 4'($urandom), 2'($urandom)};
               ext_wdata = $urandom; ext_be = 4'($urandom);
            end
         end
         #1;
         can   = (cyc != last_g + 1);
         exp_c = can && cpu_req && !(ext_req && cnt == MAX_WAIT);
         exp_e = can && ext_req && !exp_c;
         n_total++;
         if ({cpu_gnt, ext_gnt} !== {exp_c, exp_e}) $display("FAIL rnd_gnt cyc=%0d: got cpu/ext=%b want %b", cyc, {cpu_gnt, ext_gnt}, {exp_c, exp_e});
         else n_pass++;
         n_total++;
         if (cyc == last_g + 1) begin
            if ({mem_en, mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, c_we, c_addr, c_wdata, c_be})
               $display("FAIL rnd_mem cyc=%0d: got en=%b we=%b addr=%h wd=%h be=%b want 1 %b %h %h %b", cyc, mem_en, mem_we, mem_addr, mem_wdata, mem_be, c_we, c_addr, c_wdata, c_be);
            else n_pass++;
         end else begin
            if ({mem_en, mem_we, mem_addr, mem_wdata, mem_be} !== '0) $display("FAIL rnd_mem_idle cyc=%0d: got en=%b addr=%h want 0", cyc, mem_en, mem_addr);
            else n_pass++;
         end
         c_rv = 0; e_rv = 0; c_rd = '0; e_rd = '0;
         if (exp_q.size() > 0 && exp_q[0][64:33] == 32'(cyc)) begin
            ent = exp_q.pop_front();
            if (ent[32]) begin e_rv = 1; e_rd = ent[31:0]; end
            else begin c_rv = 1; c_rd = ent[31:0]; end
         end
         n_total++;
         if ({cpu_rvalid, ext_rvalid, cpu_rdata, ext_rdata} !== {c_rv, e_rv, c_rd, e_rd})
            $display("FAIL rnd_resp cyc=%0d: got rv=%b%b c=%h e=%h want rv=%b%b c=%h e=%h", cyc, cpu_rvalid, ext_rvalid, cpu_rdata, ext_rdata, c_rv, e_rv, c_rd, e_rd);
         else n_pass++;
         exp_stall = (cyc == cpu_g + 1) || ((cyc == cpu_g + 2) && cpu_g_b2b) || (cpu_req && !c_rv);
         n_total++;
         if (cpu_stall !== exp_stall) $display("FAIL rnd_stall cyc=%0d: got %b want %b", cyc, cpu_stall, exp_stall);
         else n_pass++;
         if (!ext_req || exp_e) cnt = 0;
         else if (exp_c && cnt < MAX_WAIT) cnt++;
         if (exp_c || exp_e) begin
            b2b    = (cyc == last_g + 2);
            last_g = cyc;
            c_we    = exp_e ? ext_we    : cpu_we;
            c_addr  = exp_e ? ext_addr  : cpu_addr;
            c_wdata = exp_e ? ext_wdata : cpu_wdata;
            c_be    = exp_e ? ext_be    : cpu_be;
            idx = c_addr[7:2];
            rd  = c_we ? 32'h0 : ref_mem[idx];
            if (c_we) begin
               for (int b = 0; b < 4; b++) if (c_be[b]) ref_mem[idx][b*8 +: 8] = c_wdata[b*8 +: 8];
            end
            exp_q.push_back({32'(cyc + 2), exp_e, rd});
            if (exp_c) begin cpu_g = cyc; cpu_g_b2b = b2b; c_pend = 0; end
            else e_pend = 0;
         end
      end
      @(negedge clk);
      idle_inputs();
      idle_cycles(3);
      n_total++;
      if (exp_q.size() > 1) $display("FAIL rnd_drain: got %0d pending responses want at most 1", exp_q.size());
      else n_pass++;
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      test_reset();
      test_single_read();
      test_ext_write_cpu_read();
      test_fixed_priority();
      test_drop_before_grant();
      test_reset_mid_write();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
